// File: rtl/jk_ctl_pkg.sv
// rtl/jk_ctl_pkg.sv - shared types and constants for the jump charge controller
// Purpose: sequencer state enum, walk direction encodings, velocity width.
package jk_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHARGING = 2'd1,
    LAUNCH   = 2'd2,
    AIRBORNE = 2'd3
  } state_t;

  localparam logic [1:0] WALK_NONE  = 2'b00;
  localparam logic [1:0] WALK_RIGHT = 2'b01;
  localparam logic [1:0] WALK_LEFT  = 2'b10;

  localparam int VEL_W = 16;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running 1 ms tick pulse generator
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   tick   1-cycle pulse every CLOCKS_PER_MS cycles (at terminal count)
module ms_tick_gen #(
  parameter int CLOCKS_PER_MS = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLOCKS_PER_MS > 1) ? $clog2(CLOCKS_PER_MS) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLOCKS_PER_MS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/jump_charge_ctl.sv
// rtl/jump_charge_ctl.sv - space-hold charge to jump command sequencer
// Optional feature macro: JUMP_AUTO_RELEASE_EN (launch automatically at full charge).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   key_space/left/right       held keys, synchronous to clk
//   grounded                   rectangle resting on floor
//   jump_ready                 physics accepts jump command
//   jump_valid                 jump command pending
//   jump_vy [15:0]             signed launch velocity, negative = up
//   jump_vx [7:0]              signed horizontal velocity
//   walk_dir [1:0]             01 right, 10 left, 00 none
//   charge_level [4:0]         current charge
//   charging                   high while charging
module jump_charge_ctl
  import jk_ctl_pkg::*;
#(
  parameter int CLOCKS_PER_MS  = 1_000_000,
  parameter int CHARGE_STEP_MS = 10,
  parameter int MAX_CHARGE     = 31,
  parameter int MIN_VY         = 4,
  parameter int VY_PER_LEVEL   = 1,
  parameter int VX_JUMP        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_space,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             grounded,
  input  logic             jump_ready,
  output logic             jump_valid,
  output logic [VEL_W-1:0] jump_vy,
  output logic [7:0]       jump_vx,
  output logic [1:0]       walk_dir,
  output logic [4:0]       charge_level,
  output logic             charging
);

  localparam logic [4:0]  MAX_LVL   = 5'(MAX_CHARGE);
  localparam logic [15:0] STEP_LAST = 16'(CHARGE_STEP_MS - 1);

  state_t          state;
  logic            tick;
  logic            space_prev;
  logic            air_seen;   // grounded has been seen low since leaving the floor
  logic [15:0]     step_cnt;
  logic            step_hit;
  logic [4:0]      charge_nxt;
  logic            launch_now;
  logic [1:0]      walk_req;
  logic [7:0]      vx_sel;
  logic [VEL_W-1:0] vy_mag;

  ms_tick_gen #(.CLOCKS_PER_MS(CLOCKS_PER_MS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign step_hit   = tick && (step_cnt == STEP_LAST);
  // Increment takes effect before a same-cycle release so the launch uses it.
  assign charge_nxt = (step_hit && charge_level != MAX_LVL) ? charge_level + 5'd1 : charge_level;
`ifdef JUMP_AUTO_RELEASE_EN
  assign launch_now = !key_space || (charge_nxt == MAX_LVL);
`else
  assign launch_now = !key_space;
`endif

  always_comb begin
    walk_req = WALK_NONE;
    if (grounded && key_right && !key_left) walk_req = WALK_RIGHT;
    else if (grounded && key_left && !key_right) walk_req = WALK_LEFT;
  end

  always_comb begin
    vx_sel = 8'd0;
    if (key_right && !key_left) vx_sel = 8'(VX_JUMP);
    else if (key_left && !key_right) vx_sel = -8'(VX_JUMP);
  end

  assign vy_mag   = VEL_W'(MIN_VY) + VEL_W'(VY_PER_LEVEL) * VEL_W'(charge_nxt);
  assign charging = (state == CHARGING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      space_prev   <= 1'b0;
      air_seen     <= 1'b0;
      step_cnt     <= '0;
      charge_level <= '0;
      jump_valid   <= 1'b0;
      jump_vy      <= '0;
      jump_vx      <= '0;
      walk_dir     <= WALK_NONE;
    end else begin
      space_prev <= key_space;
      case (state)
        IDLE: begin
          walk_dir <= walk_req;
          if (key_space && !space_prev && grounded) begin
            state        <= CHARGING;
            charge_level <= '0;
            step_cnt     <= '0;
            walk_dir     <= WALK_NONE;
          end
        end
        CHARGING: begin
          walk_dir <= WALK_NONE;
          if (!grounded) begin
            // Leaving the floor mid-charge aborts without a command.
            charge_level <= '0;
            air_seen     <= 1'b1;
            state        <= AIRBORNE;
          end else begin
            if (tick) step_cnt <= step_hit ? 16'd0 : step_cnt + 16'd1;
            charge_level <= charge_nxt;
            if (launch_now) begin
              jump_vy    <= -vy_mag;
              jump_vx    <= vx_sel;
              jump_valid <= 1'b1;
              state      <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (jump_ready) begin
            jump_valid   <= 1'b0;
            charge_level <= '0;
            air_seen     <= 1'b0;
            state        <= AIRBORNE;
          end
        end
        AIRBORNE: begin
          if (!grounded) air_seen <= 1'b1;
          else if (air_seen) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
